// File: rtl/beat_detector_nch.sv
// Multi-channel beat detector: rectify, peak-pick, quantise,
// then a holdoff/re-arm FSM gates a one-cycle beat pulse.
module beat_detector_nch #(
  parameter int NCH         = 3,
  parameter int DATA_W      = 16,
  parameter int TH1         = 150,
  parameter int TH2         = 370,
  parameter int TH3         = 832,
  parameter int HOLDOFF_CYC = 4,
  parameter int CNT_W       = 8,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [NCH*DATA_W-1:0] sample_data,
  input  logic [NCH-1:0]        chan_mask,
  output logic                  beat_en,
  output logic [1:0]            beat_intensity,
  output logic [CH_W-1:0]       beat_channel,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  busy
);

  localparam int HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  localparam logic [DATA_W-1:0] T1 = DATA_W'(TH1);
  localparam logic [DATA_W-1:0] T2 = DATA_W'(TH2);
  localparam logic [DATA_W-1:0] T3 = DATA_W'(TH3);
  localparam logic [DATA_W-1:0] MAG_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    ARMED,
    HOLDOFF,
    WAIT_QUIET
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mag_d [NCH];
  logic [DATA_W-1:0] mag_q [NCH];
  logic              s1_valid;

  logic [DATA_W-1:0] smp;
  logic [DATA_W-1:0] neg;

  logic [DATA_W-1:0] peak;
  logic [CH_W-1:0]   win;
  logic [1:0]        level;

  logic [HO_W-1:0]   cnt, cnt_n;
  logic              fire;

  // Rectify each channel; the most-negative code saturates.
  always_comb begin
    smp = '0;
    neg = '0;
    for (int i = 0; i < NCH; i++) begin
      smp = sample_data[i*DATA_W +: DATA_W];
      neg = ~smp + DATA_W'(1);
      if (!chan_mask[i])
        mag_d[i] = '0;
      else if (!smp[DATA_W-1])
        mag_d[i] = smp;
      else if (neg[DATA_W-1])
        mag_d[i] = MAG_MAX;
      else
        mag_d[i] = neg;
    end
  end

  // Stage 1 register: magnitudes and their valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < NCH; i++)
        mag_q[i] <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        for (int i = 0; i < NCH; i++)
          mag_q[i] <= mag_d[i];
      end
    end
  end

  // Peak pick with lowest-index tie break, then quantise.
  always_comb begin
    peak = '0;
    win  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mag_q[i] > peak) begin
        peak = mag_q[i];
        win  = CH_W'(i);
      end
    end
    if (peak >= T3)
      level = 2'd3;
    else if (peak >= T2)
      level = 2'd2;
    else if (peak >= T1)
      level = 2'd1;
    else
      level = 2'd0;
  end

  // Next-state logic for the holdoff/re-arm machine.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    unique case (state)
      ARMED: begin
        if (s1_valid && level != 2'd0) begin
          fire    = 1'b1;
          cnt_n   = HO_LOAD;
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt == '0)
          state_n = WAIT_QUIET;
        else
          cnt_n = cnt - HO_W'(1);
      end
      WAIT_QUIET: begin
        if (s1_valid && level == 2'd0)
          state_n = ARMED;
      end
      default: begin
        state_n = ARMED;
      end
    endcase
  end

  // State register and registered beat outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ARMED;
      cnt            <= '0;
      beat_en        <= 1'b0;
      beat_intensity <= 2'd0;
      beat_channel   <= '0;
      beat_count     <= '0;
      busy           <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      beat_en <= fire;
      busy    <= (state_n != ARMED);
      if (fire) begin
        beat_intensity <= level;
        beat_channel   <= win;
        beat_count     <= beat_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_beat_detector_nch.sv
// Scoreboard bench for beat_detector_nch: stimulus queues
// expected beats, a negedge monitor pops and compares them.
module tb_beat_detector_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [47:0] sample_data;
  logic [2:0]  chan_mask;
  logic        beat_en;
  logic [1:0]  beat_intensity;
  logic [1:0]  beat_channel;
  logic [7:0]  beat_count;
  logic        busy;

  always #5 clk = ~clk;

  beat_detector_nch dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .chan_mask      (chan_mask),
    .beat_en        (beat_en),
    .beat_intensity (beat_intensity),
    .beat_channel   (beat_channel),
    .beat_count     (beat_count),
    .busy           (busy)
  );

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] ch;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_count;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic       prev_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic expect_beat(input logic [1:0] lvl,
                             input logic [1:0] ch);
    exp_t e;
    exp_count++;
    e.cyc = cyc + 2;
    e.lvl = lvl;
    e.ch  = ch;
    e.cnt = exp_count;
    sb.push_back(e);
  endtask

  task automatic send(input int x, input int y, input int z,
                      input logic [2:0] m, input bit fire,
                      input logic [1:0] lvl,
                      input logic [1:0] ch, input int gap);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = {z[15:0], y[15:0], x[15:0]};
    chan_mask    = m;
    if (fire) expect_beat(lvl, ch);
    @(negedge clk);
    sample_valid = 1'b0;
    sample_data  = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic quiet();
    send(2, 2, 2, 3'b111, 1'b0, 2'd0, 2'd0, 8);
  endtask

  // Monitor: compare every beat against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (beat_en) begin
        if (prev_en) begin
          checks++;
          failures++;
          $display("FAIL beat_consecutive: got 2 beats in a row expected 1 (cycle %0d)",
                   cyc);
        end
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got beat_en=1 expected 0 (cycle %0d)",
                   cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_intensity", beat_intensity, e.lvl);
          chk("beat_channel", beat_channel, e.ch);
          chk("beat_count", beat_count, e.cnt);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_beat: got beat_en=0 expected 1 (cycle %0d)",
                 e.cyc);
      end
    end
    prev_en = beat_en;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    chan_mask    = '0;
    exp_count    = '0;
    repeat (3) @(negedge clk);
    chk("rst_beat_en", beat_en, 0);
    chk("rst_intensity", beat_intensity, 0);
    chk("rst_channel", beat_channel, 0);
    chk("rst_count", beat_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // 1: threshold-1 boundary on ch0
    send(150, 2, 2, 3'b111, 1'b1, 2'd1, 2'd0, 8);
    chk("busy_wait_quiet", busy, 1);
    quiet();
    chk("busy_rearmed", busy, 0);

    // 2: levels 2 and 3, negative sample
    send(2, 370, 2, 3'b111, 1'b1, 2'd2, 2'd1, 8);
    quiet();
    send(2, 2, -832, 3'b111, 1'b1, 2'd3, 2'd2, 8);
    quiet();

    // 3: just below TH1, then saturating most-negative
    send(149, 0, 0, 3'b111, 1'b0, 2'd0, 2'd0, 8);
    send(-32768, 0, 0, 3'b111, 1'b1, 2'd3, 2'd0, 8);
    quiet();

    // 4: tie, masked tie, all-masked
    send(370, 370, 0, 3'b111, 1'b1, 2'd2, 2'd0, 8);
    quiet();
    send(370, 370, 0, 3'b110, 1'b1, 2'd2, 2'd1, 8);
    quiet();
    send(0, 0, 832, 3'b000, 1'b0, 2'd0, 2'd0, 8);
    chk("busy_mask0", busy, 0);

    // 5: back-to-back loud samples give one beat
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_data  = {16'd0, 16'd832, 16'd0};
      chan_mask    = 3'b111;
      if (i == 0) expect_beat(2'd3, 2'd1);
      if (i >= 3) chk("busy_burst", busy, 1);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    sample_data  = '0;
    repeat (8) @(negedge clk);
    chk("busy_after_burst", busy, 1);
    send(0, 0, 0, 3'b111, 1'b0, 2'd0, 2'd0, 8);
    chk("busy_quiet_rearm", busy, 0);
    send(0, 832, 0, 3'b111, 1'b1, 2'd3, 2'd1, 8);

    // 6: reset during holdoff with a sample in flight
    quiet();
    send(832, 0, 0, 3'b111, 1'b1, 2'd3, 2'd0, 0);
    send(0, 832, 0, 3'b111, 1'b0, 2'd0, 2'd0, 0);
    chk("busy_holdoff", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst6_beat_en", beat_en, 0);
    chk("rst6_intensity", beat_intensity, 0);
    chk("rst6_channel", beat_channel, 0);
    chk("rst6_count", beat_count, 0);
    chk("rst6_busy", busy, 0);
    chk("rst6_sb_empty", sb.size(), 0);
    sb.delete();
    exp_count = '0;
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // in-flight loud sample while armed is discarded by reset
    send(832, 0, 0, 3'b111, 1'b0, 2'd0, 2'd0, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_inflight_busy", busy, 0);

    // 256 beats wrap the counter
    for (int i = 0; i < 256; i++) begin
      send(0, 0, 0, 3'b111, 1'b0, 2'd0, 2'd0, 0);
      send(0, 0, 832, 3'b111, 1'b1, 2'd3, 2'd2, 8);
    end
    chk("count_wrap", beat_count, 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
